// File: rtl/id_decode_stage.sv
// id_decode_stage: registered MIPS-I decode stage between IF/ID and register-file read.
//
// Accepts one instruction plus its PC+4 per valid/ready beat. The instruction is decoded
// combinationally on the way in, and only the decoded fields are stored. A two-entry
// (main + skid) buffer lets downstream stall without a combinational i_ready -> o_ready path.
//
// Optional feature: define ID_DECODE_ILLEGAL_EN to flag unsupported opcodes on o_illegal.
// When the macro is undefined there is no check logic and o_illegal is tied low.
//
// Ports:
//   i_clk, i_reset     clock (rising edge), asynchronous active-high reset
//   i_flush            synchronous kill of every held beat
//   i_valid, o_ready   upstream handshake; o_ready comes straight from the state register
//   i_instruction      raw 32-bit instruction
//   i_pc_plus4         PC+4 of the instruction
//   o_valid, i_ready   downstream handshake
//   o_opcode .. o_funct  raw instruction fields
//   o_imm              zero-, LUI- or sign-extended immediate
//   o_jtarget          {pc_plus4[top:28], instr[25:0], 2'b00}
//   o_type             00 R-type, 01 I-type, 10 J-type
//   o_wreg             destination register index
//   o_pc_plus4         PC+4 passthrough
//   o_illegal          unsupported opcode (only when ID_DECODE_ILLEGAL_EN is defined)
module id_decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_instruction,
  input  logic [PC_WIDTH-1:0] i_pc_plus4,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [5:0]          o_opcode,
  output logic [4:0]          o_rs,
  output logic [4:0]          o_rt,
  output logic [4:0]          o_rd,
  output logic [4:0]          o_shamt,
  output logic [5:0]          o_funct,
  output logic [XLEN-1:0]     o_imm,
  output logic [PC_WIDTH-1:0] o_jtarget,
  output logic [1:0]          o_type,
  output logic [4:0]          o_wreg,
  output logic [PC_WIDTH-1:0] o_pc_plus4,
  output logic                o_illegal
);

  typedef struct packed {
    logic [5:0]          opcode;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [4:0]          shamt;
    logic [5:0]          funct;
    logic [XLEN-1:0]     imm;
    logic [PC_WIDTH-1:0] jtarget;
    logic [1:0]          itype;
    logic [4:0]          wreg;
    logic [PC_WIDTH-1:0] pc_plus4;
`ifdef ID_DECODE_ILLEGAL_EN
    logic                illegal;
`endif
  } beat_t;

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  beat_t  dec;
  logic   in_fire, out_fire;
  logic [15:0] imm16;

  // Combinational decode of the incoming instruction.
  always_comb begin
    dec          = '0;
    imm16        = i_instruction[15:0];
    dec.opcode   = i_instruction[31:26];
    dec.rs       = i_instruction[25:21];
    dec.rt       = i_instruction[20:16];
    dec.rd       = i_instruction[15:11];
    dec.shamt    = i_instruction[10:6];
    dec.funct    = i_instruction[5:0];
    dec.pc_plus4 = i_pc_plus4;

    case (dec.opcode)
      6'h0C, 6'h0D, 6'h0E: dec.imm = XLEN'(imm16);
      6'h0F:               dec.imm = XLEN'({imm16, 16'h0000});
      default:             dec.imm = XLEN'($signed(imm16));
    endcase

    // Upper PC bits kept, low 28 bits replaced by the word-aligned jump index.
    dec.jtarget       = i_pc_plus4;
    dec.jtarget[27:0] = {i_instruction[25:0], 2'b00};

    case (dec.opcode)
      6'h00:        dec.itype = 2'b00;
      6'h02, 6'h03: dec.itype = 2'b10;
      default:      dec.itype = 2'b01;
    endcase

    case (dec.opcode)
      6'h00:                      dec.wreg = dec.rd;
      6'h03:                      dec.wreg = 5'd31;
      6'h02, 6'h04, 6'h05, 6'h2B: dec.wreg = 5'd0;
      default:                    dec.wreg = dec.rt;
    endcase

`ifdef ID_DECODE_ILLEGAL_EN
    case (dec.opcode)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
      6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: dec.illegal = 1'b0;
      default:                                         dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.wreg = 5'd0;
    end
`endif
  end

  // Both handshake outputs depend only on the state register.
  assign o_ready = (state_q != StSkid);
  assign o_valid = (state_q != StEmpty);

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = dec;
          state_d = StFull;
        end
      end
      StFull: begin
        if (in_fire && out_fire) begin
          main_d = dec;
        end else if (in_fire) begin
          skid_d  = dec;
          state_d = StSkid;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        // o_ready is low here, so no new beat can arrive.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops every beat; data registers keep stale contents behind o_valid=0.
    if (i_flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign o_opcode   = main_q.opcode;
  assign o_rs       = main_q.rs;
  assign o_rt       = main_q.rt;
  assign o_rd       = main_q.rd;
  assign o_shamt    = main_q.shamt;
  assign o_funct    = main_q.funct;
  assign o_imm      = main_q.imm;
  assign o_jtarget  = main_q.jtarget;
  assign o_type     = main_q.itype;
  assign o_wreg     = main_q.wreg;
  assign o_pc_plus4 = main_q.pc_plus4;
`ifdef ID_DECODE_ILLEGAL_EN
  assign o_illegal  = main_q.illegal;
`else
  assign o_illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed spec vectors followed by random traffic, all checked
// against a two-slot FIFO model whose entries are decoded from the MIPS-I field rules.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] imm;
  logic [31:0] jtarget;
  logic [1:0]  itype;
  logic [4:0]  wreg;
  logic [31:0] pc4_out;
  logic        illegal;

  id_decode_stage #(.XLEN(32), .PC_WIDTH(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(in_ready),
    .i_instruction(instr), .i_pc_plus4(pc4), .o_valid(out_valid), .i_ready(out_ready),
    .o_opcode(opcode), .o_rs(rs), .o_rt(rt), .o_rd(rd), .o_shamt(shamt), .o_funct(funct),
    .o_imm(imm), .o_jtarget(jtarget), .o_type(itype), .o_wreg(wreg), .o_pc_plus4(pc4_out),
    .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } beat_t;

  typedef struct {
    int unsigned op, rs, rt, rd, sh, fn, imm, jt, ty, wr, il;
  } exp_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int unsigned w   = ins;
    int unsigned i16 = w & 32'hFFFF;
    e.op = w >> 26;
    e.rs = (w >> 21) & 31;
    e.rt = (w >> 16) & 31;
    e.rd = (w >> 11) & 31;
    e.sh = (w >> 6) & 31;
    e.fn = w & 63;
    if (e.op == 'h0C || e.op == 'h0D || e.op == 'h0E) e.imm = i16;
    else if (e.op == 'h0F) e.imm = i16 * 65536;
    else if (i16 >= 32768) e.imm = 32'hFFFF0000 + i16;
    else e.imm = i16;
    e.jt = (pc & 32'hF000_0000) + (w & 32'h03FF_FFFF) * 4;
    if (e.op == 0) e.ty = 0;
    else if (e.op == 2 || e.op == 3) e.ty = 2;
    else e.ty = 1;
    if (e.op == 0) e.wr = e.rd;
    else if (e.op == 3) e.wr = 31;
    else if (e.op == 2 || e.op == 4 || e.op == 5 || e.op == 'h2B) e.wr = 0;
    else e.wr = e.rt;
`ifdef ID_DECODE_ILLEGAL_EN
    e.il = (e.op inside {'h00, 'h02, 'h03, 'h04, 'h05, 'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D,
                         'h0E, 'h0F, 'h23, 'h2B}) ? 0 : 1;
    if (e.il == 1) e.wr = 0;
`else
    e.il = 0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's head-of-queue beat.
  task automatic check_outputs();
    exp_t e;
    chk("o_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("o_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      e = ref_decode(q[0].ins, q[0].pc);
      chk("opcode", 64'(opcode), 64'(e.op));
      chk("rs", 64'(rs), 64'(e.rs));
      chk("rt", 64'(rt), 64'(e.rt));
      chk("rd", 64'(rd), 64'(e.rd));
      chk("shamt", 64'(shamt), 64'(e.sh));
      chk("funct", 64'(funct), 64'(e.fn));
      chk("imm", 64'(imm), 64'(e.imm));
      chk("jtarget", 64'(jtarget), 64'(e.jt));
      chk("type", 64'(itype), 64'(e.ty));
      chk("wreg", 64'(wreg), 64'(e.wr));
      chk("pc_plus4", 64'(pc4_out), 64'(q[0].pc));
      chk("illegal", 64'(illegal), 64'(e.il));
    end
  endtask

  // One cycle: check outputs, drive inputs, then advance the model at the rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl, output logic acc);
    logic in_fire, out_fire;
    beat_t b;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    instr     = ins;
    pc4       = pc;
    out_ready = rdy;
    flush     = fl;
    in_fire   = v && (q.size() < 2);
    out_fire  = rdy && (q.size() > 0);
    @(posedge clk);
    acc = in_fire && !fl;
    if (fl) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin
        b.ins = ins;
        b.pc  = pc;
        q.push_back(b);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h01, 6'h10};
    logic [31:0] r = $urandom;
    return {ops[$urandom_range(0, 17)], r[25:0]};
  endfunction

  initial begin
    logic        acc;
    logic        have;
    logic        fl, rdy;
    logic [31:0] rins, rpc;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; pc4 = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_rs", 64'(rs), 64'd0);
    chk("rst_jtarget", 64'(jtarget), 64'd0);
    chk("rst_pc", 64'(pc4_out), 64'd0);
    rst = 1'b0;

    // Spec decode vectors.
    step(1'b1, 32'h012A4020, 32'h0040_0004, 1'b1, 1'b0, acc);
    #1;
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_rs", 64'(rs), 64'd9);
    chk("add_rt", 64'(rt), 64'd10);
    chk("add_rd", 64'(rd), 64'd8);
    chk("add_funct", 64'(funct), 64'h20);
    chk("add_type", 64'(itype), 64'd0);
    chk("add_wreg", 64'(wreg), 64'd8);
    step(1'b1, 32'h2008FFFF, 32'h0040_0008, 1'b1, 1'b0, acc);
    #1;
    chk("addi_imm", 64'(imm), 64'hFFFF_FFFF);
    chk("addi_wreg", 64'(wreg), 64'd8);
    step(1'b1, 32'h3508FFFF, 32'h0040_000C, 1'b1, 1'b0, acc);
    #1;
    chk("ori_imm", 64'(imm), 64'h0000_FFFF);
    step(1'b1, 32'h3C081234, 32'h0040_0010, 1'b1, 1'b0, acc);
    #1;
    chk("lui_imm", 64'(imm), 64'h1234_0000);
    step(1'b1, 32'h0C000010, 32'h4000_0004, 1'b1, 1'b0, acc);
    #1;
    chk("jal_jtarget", 64'(jtarget), 64'h4000_0040);
    chk("jal_type", 64'(itype), 64'd2);
    chk("jal_wreg", 64'(wreg), 64'd31);
    step(1'b1, 32'hFC000000, 32'h0040_0018, 1'b1, 1'b0, acc);
    #1;
`ifdef ID_DECODE_ILLEGAL_EN
    chk("ill_flag", 64'(illegal), 64'd1);
`else
    chk("ill_flag", 64'(illegal), 64'd0);
`endif
    chk("ill_wreg", 64'(wreg), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // Back-to-back beats into a stalled downstream.
    step(1'b1, 32'h2001_0001, 32'h100, 1'b0, 1'b0, acc);
    #1 chk("bb_ready1", 64'(in_ready), 64'd1);
    step(1'b1, 32'h2002_0002, 32'h104, 1'b0, 1'b0, acc);
    #1 chk("bb_ready2", 64'(in_ready), 64'd0);
    step(1'b1, 32'h2003_0003, 32'h108, 1'b0, 1'b0, acc);
    chk("bb_reject", 64'(acc), 64'd0);
    step(1'b1, 32'h2003_0003, 32'h108, 1'b1, 1'b0, acc);
    step(1'b1, 32'h2003_0003, 32'h108, 1'b1, 1'b0, acc);
    chk("bb_accept3", 64'(acc), 64'd1);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // Flush while the skid entry is occupied, with a new beat offered.
    step(1'b1, 32'h8C01_0010, 32'h200, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8C02_0020, 32'h204, 1'b0, 1'b0, acc);
    step(1'b1, 32'h8C03_0030, 32'h208, 1'b0, 1'b1, acc);
    #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // Reset in the middle of traffic.
    step(1'b1, 32'h2404_1111, 32'h300, 1'b0, 1'b0, acc);
    step(1'b1, 32'h2405_2222, 32'h304, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd1);
    chk("mrst_imm", 64'(imm), 64'd0);
    chk("mrst_pc", 64'(pc4_out), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic; an offered beat is held until it is accepted or flushed.
    have = 1'b0;
    rins = '0;
    rpc  = '0;
    for (int c = 0; c < 500; c++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1'b1;
        rins = rand_instr();
        rpc  = $urandom;
      end
      fl  = ($urandom_range(0, 31) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(have, rins, rpc, rdy, fl, acc);
      if (acc || fl) have = 1'b0;
    end
    repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
